spu_wb_sched: RTL and testbench
===============================

Name: spu_wb_sched

Overview:
Writeback scheduler and scoreboard for the SPU 128x128 register file.
- Tracks in-flight destination registers for the dual-issue front end and raises stall on RAW, WAW and intra-pair hazards.
- Arbitrates even-pipe and odd-pipe results onto the register file's single write port (regwrite/wa/wd).
- Sits between the issue stage, the two execution pipes and regfile.

Parameters:
RFWIDTH, 128, register/data width in bits
REGBITS, 7, register address width (2^REGBITS registers, all general purpose, no hardwired zero)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
iss_valid_0  in  1  slot-0 instruction presented for issue
iss_ra_0  in  REGBITS  slot-0 source A
iss_rb_0  in  REGBITS  slot-0 source B
iss_rt_0  in  REGBITS  slot-0 destination
iss_valid_1  in  1  slot-1 instruction presented
iss_ra_1  in  REGBITS  slot-1 source A
iss_rb_1  in  REGBITS  slot-1 source B
iss_rt_1  in  REGBITS  slot-1 destination
stall  out  1  combinational; pair not accepted this cycle
wb_valid_e  in  1  even-pipe result valid
wb_rt_e  in  REGBITS  even-pipe result register
wb_data_e  in  RFWIDTH  even-pipe result data
wb_ready_e  out  1  even-pipe buffer can accept
wb_valid_o  in  1  odd-pipe result valid
wb_rt_o  in  REGBITS  odd-pipe result register
wb_data_o  in  RFWIDTH  odd-pipe result data
wb_ready_o  out  1  odd-pipe buffer can accept
regwrite  out  1  registered write enable to regfile
wa  out  REGBITS  registered write address
wd  out  RFWIDTH  registered write data
wb_err  out  1  sticky; write to a non-busy register seen

Behaviour:
Reset
- busy[] is all 0.
- FIFOs empty; round-robin pointer = even.
- regwrite=0, wa=0, wd=0, wb_err=0.
- Reset takes effect asynchronously mid-operation: buffered results are discarded, no write is issued after release.

Scoreboard
- busy bit per register.
- hz0 = iss_valid_0 & (busy[ra_0] | busy[rb_0] | busy[rt_0]).
- hz1 = iss_valid_1 & (busy[ra_1] | busy[rb_1] | busy[rt_1] | (iss_valid_0 & rt_0 in {ra_1, rb_1, rt_1})).
- stall = hz0 | hz1.
- The pair issues atomically. When stall=0, set busy[rt] for each valid slot at the clock edge.

Writeback buffering
- Each pipe has a 2-entry FIFO of {rt, data}.
- wb_ready_x = FIFO count < 2, registered-free (derived from count).
- Push when valid & ready. Valid while not ready: the pipe holds; the value is not captured.

Arbitration
- One grant per cycle, taken from FIFO heads.
- Only one side non-empty: grant it.
- Both non-empty: grant the side the pointer selects, then flip the pointer to the other side.
- A grant pops the head and loads regwrite=1, wa=rt, wd=data at the edge. No grant: regwrite=0 (wa/wd hold).

Latency
- Result accepted at edge ending cycle N, uncontended: regwrite=1 during cycle N+1 and the regfile writes at the end of N+1.
- busy[wa] is cleared at that same edge. Dependent stall drops in cycle N+2.

Simultaneous events
- Push and pop on the same FIFO in the same cycle: count unchanged; legal when full.
- Set and clear of the same busy bit at the same edge: set wins. This is unreachable through normal issue and is kept as a defensive rule.

Error
- Grant to a register whose busy bit is 0: the write still occurs and wb_err is set.
- wb_err is cleared only by reset.

Decomposition:
- Package spu_pkg: RFWIDTH, REGBITS, NREGS=128, and the wb entry struct/width {rt, data}.
- One sub-module, spu_wb_fifo2 (2-entry FIFO with count, push/pop, head outputs), instantiated for even and odd.
- Scoreboard and arbiter are implemented inline.

Test Plan:
1. Hold reset, then release -> regwrite=0, wb_ready_e=wb_ready_o=1, stall=0 with iss_valid=0, wb_err=0.
2. Issue rt_0=5, rt_1=9 at cycle 0, then ra_0=5 from cycle 1 -> stall=1. Even result rt=5, data=0xAA accepted at cycle 2 -> regwrite=1, wa=5, wd=0xAA in cycle 3; stall=0 in cycle 4.
3. iss_valid_0/1 with rt_0=3, ra_1=3 and an idle scoreboard -> stall=1, busy[3] stays 0. Change ra_1 to 4 -> stall=0, busy[3] and busy[rt_1] set.
4. Issue rt 10..17, then push even rt 10,12,14,16 and odd rt 11,13,15,17 every cycle with valid held -> writes strictly alternate 10,11,12,...,17 (even first); wb_ready toggles only on full; no result lost or duplicated.
5. Even result to reg 20 with busy[20]=0 -> regwrite=1, wa=20 next cycle; wb_err=1 and stays 1 through later traffic.
6. Fill both FIFOs with 2 entries and assert reset mid-cycle -> regwrite=0 immediately. After release: no writes, busy all 0, wb_ready=1.

Source files
------------

// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared widths and writeback entry type for the SPU writeback scheduler
package spu_pkg;

  localparam int RFWIDTH = 128;
  localparam int REGBITS = 7;
  localparam int NREGS   = 1 << REGBITS;

  typedef struct packed {
    logic [REGBITS-1:0] rt;
    logic [RFWIDTH-1:0] data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/spu_wb_fifo2.sv
// rtl/spu_wb_fifo2.sv - 2-entry result FIFO; an empty FIFO presents the incoming entry as its head
module spu_wb_fifo2
  import spu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WB_ENTRY_W-1:0] i_din,
  input  logic                  i_pop,
  output logic                  o_ready,
  output logic                  o_head_valid,
  output logic [WB_ENTRY_W-1:0] o_head
);

  logic [WB_ENTRY_W-1:0] r_mem [2];
  logic                  r_rd;
  logic                  r_wr;
  logic [1:0]            r_count;

  logic w_empty;
  logic w_push;
  logic w_store;
  logic w_deq;

  assign w_empty = (r_count == 2'd0);
  assign o_ready = (r_count != 2'd2);
  assign w_push  = i_push & o_ready;
  // An entry popped straight through an empty FIFO never occupies a slot.
  assign w_store = w_push & ~(w_empty & i_pop);
  assign w_deq   = i_pop & ~w_empty;

  assign o_head_valid = ~w_empty | w_push;
  assign o_head       = w_empty ? i_din : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_store) r_wr <= ~r_wr;
      if (w_deq)   r_rd <= ~r_rd;
      case ({w_store, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spu_wb_sched.sv
// rtl/spu_wb_sched.sv - register scoreboard for dual issue plus even/odd writeback arbiter
module spu_wb_sched
  import spu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               iss_valid_0,
  input  logic [REGBITS-1:0] iss_ra_0,
  input  logic [REGBITS-1:0] iss_rb_0,
  input  logic [REGBITS-1:0] iss_rt_0,
  input  logic               iss_valid_1,
  input  logic [REGBITS-1:0] iss_ra_1,
  input  logic [REGBITS-1:0] iss_rb_1,
  input  logic [REGBITS-1:0] iss_rt_1,
  output logic               stall,
  input  logic               wb_valid_e,
  input  logic [REGBITS-1:0] wb_rt_e,
  input  logic [RFWIDTH-1:0] wb_data_e,
  output logic               wb_ready_e,
  input  logic               wb_valid_o,
  input  logic [REGBITS-1:0] wb_rt_o,
  input  logic [RFWIDTH-1:0] wb_data_o,
  output logic               wb_ready_o,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [RFWIDTH-1:0] wd,
  output logic               wb_err
);

  logic [NREGS-1:0]   r_busy;
  logic               r_rr_odd;
  logic               r_regwrite;
  logic [REGBITS-1:0] r_wa;
  logic [RFWIDTH-1:0] r_wd;
  logic               r_err;

  logic             w_hz0;
  logic             w_hz1;
  logic             w_pair_dep;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  logic      w_hv_e;
  logic      w_hv_o;
  wb_entry_t w_head_e;
  wb_entry_t w_head_o;
  logic      w_grant_e;
  logic      w_grant_o;
  logic      w_grant;
  wb_entry_t w_sel;

  assign w_hz0 = iss_valid_0 & (r_busy[iss_ra_0] | r_busy[iss_rb_0] | r_busy[iss_rt_0]);
  assign w_pair_dep = iss_valid_0 &
                      ((iss_rt_0 == iss_ra_1) | (iss_rt_0 == iss_rb_1) | (iss_rt_0 == iss_rt_1));
  assign w_hz1 = iss_valid_1 &
                 (r_busy[iss_ra_1] | r_busy[iss_rb_1] | r_busy[iss_rt_1] | w_pair_dep);
  assign stall = w_hz0 | w_hz1;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (!stall && iss_valid_0) w_set[iss_rt_0] = 1'b1;
    if (!stall && iss_valid_1) w_set[iss_rt_1] = 1'b1;
    // Busy drops on the edge where the regfile actually commits the write.
    if (r_regwrite) w_clr[r_wa] = 1'b1;
  end

  spu_wb_fifo2 u_fifo_e (
    .clk          (clk),
    .reset        (reset),
    .i_push       (wb_valid_e),
    .i_din        ({wb_rt_e, wb_data_e}),
    .i_pop        (w_grant_e),
    .o_ready      (wb_ready_e),
    .o_head_valid (w_hv_e),
    .o_head       (w_head_e)
  );

  spu_wb_fifo2 u_fifo_o (
    .clk          (clk),
    .reset        (reset),
    .i_push       (wb_valid_o),
    .i_din        ({wb_rt_o, wb_data_o}),
    .i_pop        (w_grant_o),
    .o_ready      (wb_ready_o),
    .o_head_valid (w_hv_o),
    .o_head       (w_head_o)
  );

  assign w_grant_e = w_hv_e & (~w_hv_o | ~r_rr_odd);
  assign w_grant_o = w_hv_o & ~w_grant_e;
  assign w_grant   = w_grant_e | w_grant_o;
  assign w_sel     = w_grant_e ? w_head_e : w_head_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_rr_odd   <= 1'b0;
      r_regwrite <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= (r_busy & ~w_clr) | w_set;
      r_regwrite <= w_grant;
      if (w_hv_e && w_hv_o) r_rr_odd <= ~r_rr_odd;
      if (w_grant) begin
        r_wa <= w_sel.rt;
        r_wd <= w_sel.data;
        if (!r_busy[w_sel.rt]) r_err <= 1'b1;
      end
    end
  end

  assign regwrite = r_regwrite;
  assign wa       = r_wa;
  assign wd       = r_wd;
  assign wb_err   = r_err;

endmodule

// File: tb/tb_spu_wb_sched.sv
// tb/tb_spu_wb_sched.sv - directed self-checking bench for spu_wb_sched
module tb_spu_wb_sched;
  import spu_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               iss_valid_0, iss_valid_1;
  logic [REGBITS-1:0] iss_ra_0, iss_rb_0, iss_rt_0;
  logic [REGBITS-1:0] iss_ra_1, iss_rb_1, iss_rt_1;
  logic               stall;
  logic               wb_valid_e, wb_valid_o;
  logic [REGBITS-1:0] wb_rt_e, wb_rt_o;
  logic [RFWIDTH-1:0] wb_data_e, wb_data_o;
  logic               wb_ready_e, wb_ready_o;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [RFWIDTH-1:0] wd;
  logic               wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spu_wb_sched dut (
    .clk         (clk),
    .reset       (reset),
    .iss_valid_0 (iss_valid_0),
    .iss_ra_0    (iss_ra_0),
    .iss_rb_0    (iss_rb_0),
    .iss_rt_0    (iss_rt_0),
    .iss_valid_1 (iss_valid_1),
    .iss_ra_1    (iss_ra_1),
    .iss_rb_1    (iss_rb_1),
    .iss_rt_1    (iss_rt_1),
    .stall       (stall),
    .wb_valid_e  (wb_valid_e),
    .wb_rt_e     (wb_rt_e),
    .wb_data_e   (wb_data_e),
    .wb_ready_e  (wb_ready_e),
    .wb_valid_o  (wb_valid_o),
    .wb_rt_o     (wb_rt_o),
    .wb_data_o   (wb_data_o),
    .wb_ready_o  (wb_ready_o),
    .regwrite    (regwrite),
    .wa          (wa),
    .wd          (wd),
    .wb_err      (wb_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    iss_valid_0 = 1'b0; iss_ra_0 = '0; iss_rb_0 = '0; iss_rt_0 = '0;
    iss_valid_1 = 1'b0; iss_ra_1 = '0; iss_rb_1 = '0; iss_rt_1 = '0;
    wb_valid_e  = 1'b0; wb_rt_e  = '0; wb_data_e = '0;
    wb_valid_o  = 1'b0; wb_rt_o  = '0; wb_data_o = '0;
  endtask

  logic               mon_en = 1'b0;
  logic [REGBITS-1:0] wq [$];
  logic [RFWIDTH-1:0] dq [$];

  always @(negedge clk) begin
    if (mon_en && regwrite) begin
      wq.push_back(wa);
      dq.push_back(wd);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end

  initial begin
    int ei, oi, stall_o, nw;
    logic re, ro;

    // reset state
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_regwrite", regwrite, 0);
    check("rst_ready_e", wb_ready_e, 1);
    check("rst_ready_o", wb_ready_o, 1);
    check("rst_stall", stall, 0);
    check("rst_err", wb_err, 0);

    // RAW stall and writeback latency
    iss_valid_0 = 1; iss_ra_0 = 1; iss_rb_0 = 2; iss_rt_0 = 5;
    iss_valid_1 = 1; iss_ra_1 = 6; iss_rb_1 = 7; iss_rt_1 = 9;
    #1 check("t2_issue", stall, 0);
    tick();
    iss_valid_1 = 0; iss_ra_0 = 5; iss_rb_0 = 2; iss_rt_0 = 30;
    #1 check("t2_raw_stall", stall, 1);
    tick();
    wb_valid_e = 1; wb_rt_e = 5; wb_data_e = 'hAA;
    #1 check("t2_ready_e", wb_ready_e, 1);
    check("t2_stall_c2", stall, 1);
    tick();
    wb_valid_e = 0;
    #1 check("t2_regwrite", regwrite, 1);
    check("t2_wa", wa, 5);
    check("t2_wd", wd, 'hAA);
    check("t2_stall_c3", stall, 1);
    tick();
    #1 check("t2_stall_c4", stall, 0);
    check("t2_regwrite_c4", regwrite, 0);
    check("t2_err", wb_err, 0);
    iss_valid_0 = 0;

    // intra-pair hazards
    iss_valid_0 = 1; iss_ra_0 = 40; iss_rb_0 = 41; iss_rt_0 = 3;
    iss_valid_1 = 1; iss_ra_1 = 3;  iss_rb_1 = 42; iss_rt_1 = 43;
    #1 check("t3_pair_raw", stall, 1);
    tick();
    iss_ra_1 = 4;
    #1 check("t3_pair_ok", stall, 0);
    tick();
    iss_valid_1 = 0; iss_ra_0 = 3; iss_rb_0 = 41; iss_rt_0 = 44;
    #1 check("t3_busy3", stall, 1);
    iss_ra_0 = 40; iss_rb_0 = 43;
    #1 check("t3_busy43", stall, 1);
    iss_rb_0 = 41; iss_rt_0 = 60;
    iss_valid_1 = 1; iss_ra_1 = 61; iss_rb_1 = 62; iss_rt_1 = 60;
    #1 check("t3_pair_waw", stall, 1);
    iss_rt_1 = 63;
    #1 check("t3_pair_free", stall, 0);
    iss_valid_0 = 0; iss_valid_1 = 0;
    tick();

    // alternating arbitration under back-pressure
    for (int p = 0; p < 4; p++) begin
      iss_valid_0 = 1; iss_ra_0 = 100; iss_rb_0 = 101; iss_rt_0 = REGBITS'(10 + 2 * p);
      iss_valid_1 = 1; iss_ra_1 = 100; iss_rb_1 = 101; iss_rt_1 = REGBITS'(11 + 2 * p);
      #1 check("t4_issue", stall, 0);
      tick();
    end
    iss_valid_0 = 0; iss_valid_1 = 0;
    mon_en = 1;
    ei = 0; oi = 0; stall_o = 0;
    for (int c = 0; c < 30 && (ei < 4 || oi < 4); c++) begin
      wb_valid_e = (ei < 4); wb_rt_e = REGBITS'(10 + 2 * ei); wb_data_e = RFWIDTH'('hD000 + 10 + 2 * ei);
      wb_valid_o = (oi < 4); wb_rt_o = REGBITS'(11 + 2 * oi); wb_data_o = RFWIDTH'('hD000 + 11 + 2 * oi);
      @(negedge clk);
      re = wb_ready_e; ro = wb_ready_o;
      if (wb_valid_o && !ro) stall_o++;
      @(posedge clk);
      #1;
      if (wb_valid_e && re) ei++;
      if (wb_valid_o && ro) oi++;
    end
    wb_valid_e = 0; wb_valid_o = 0;
    repeat (6) tick();
    mon_en = 0;
    check("t4_pushed", (ei == 4) && (oi == 4), 1);
    check("t4_nwrites", wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wq.size()) begin
        check("t4_wa", wq[i], 10 + i);
        check("t4_wd", dq[i], 'hD000 + 10 + i);
      end
    end
    check("t4_odd_hold", stall_o, 1);
    check("t4_err", wb_err, 0);

    // write to an idle register sets the sticky error
    wb_valid_e = 1; wb_rt_e = 20; wb_data_e = 'h55;
    #1 check("t5_ready_e", wb_ready_e, 1);
    tick();
    wb_valid_e = 0;
    #1 check("t5_regwrite", regwrite, 1);
    check("t5_wa", wa, 20);
    check("t5_wd", wd, 'h55);
    check("t5_err", wb_err, 1);
    iss_valid_0 = 1; iss_ra_0 = 100; iss_rb_0 = 101; iss_rt_0 = 21;
    #1 check("t5_issue21", stall, 0);
    tick();
    iss_valid_0 = 0;
    wb_valid_o = 1; wb_rt_o = 21; wb_data_o = 'h77;
    tick();
    wb_valid_o = 0;
    #1 check("t5_wa21", wa, 21);
    check("t5_err_hold", wb_err, 1);
    repeat (3) tick();
    check("t5_err_sticky", wb_err, 1);

    // reset with buffered results
    iss_valid_0 = 1; iss_ra_0 = 100; iss_rb_0 = 101; iss_rt_0 = 70;
    iss_valid_1 = 1; iss_ra_1 = 100; iss_rb_1 = 101; iss_rt_1 = 71;
    tick();
    iss_valid_0 = 0; iss_valid_1 = 0;
    wb_valid_e = 1; wb_rt_e = 80; wb_data_e = 'h1;
    wb_valid_o = 1; wb_rt_o = 81; wb_data_o = 'h2;
    repeat (4) tick();
    check("t6_full", wb_ready_e & wb_ready_o, 0);
    check("t6_busy_wr", regwrite, 1);
    #1 reset = 1'b1;
    #1 check("t6_async_regwrite", regwrite, 0);
    check("t6_async_err", wb_err, 0);
    wb_valid_e = 0; wb_valid_o = 0;
    repeat (2) tick();
    reset = 1'b0;
    nw = 0;
    repeat (6) begin
      @(negedge clk);
      if (regwrite) nw++;
    end
    check("t6_no_writes", nw, 0);
    check("t6_wa", wa, 0);
    check("t6_wd", wd, 0);
    check("t6_ready_e", wb_ready_e, 1);
    check("t6_ready_o", wb_ready_o, 1);
    iss_valid_0 = 1; iss_ra_0 = 70; iss_rb_0 = 71; iss_rt_0 = 72;
    iss_valid_1 = 1; iss_ra_1 = 3;  iss_rb_1 = 43; iss_rt_1 = 9;
    #1 check("t6_busy_clear", stall, 0);
    iss_valid_0 = 0; iss_valid_1 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
